// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared az_bus master port.
// Grants hold across locked transfers; a watchdog reclaims a stalled bus.
module bus_arbiter #(
  parameter  int NUM_M   = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDX_W   = $clog2(NUM_M),
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_M-1:0] m_req,
  input  logic [NUM_M-1:0] m_lock,
  input  logic             bus_ack,
  output logic [NUM_M-1:0] m_gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             bus_busy,
  output logic             timeout_pulse,
  output logic [7:0]       timeout_cnt
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state, state_n;
  logic [NUM_M-1:0] gnt_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W-1:0] rr_ptr, ptr_n;
  logic [IDX_W-1:0] win;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic             tp_n;
  logic [7:0]       tcnt_n;

  // First requester strictly after ptr, wrapping modulo NUM_M.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_M-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= NUM_M; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NUM_M);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign win      = rr_pick(m_req, rr_ptr);
  assign bus_busy = (state == OWN);

  always_comb begin
    state_n = state;
    gnt_n   = m_gnt;
    idx_n   = gnt_idx;
    ptr_n   = rr_ptr;
    hold_n  = hold_cnt;
    tp_n    = 1'b0;
    tcnt_n  = timeout_cnt;
    unique case (state)
      IDLE: begin
        if (|m_req) begin
          state_n = OWN;
          gnt_n   = NUM_M'(1) << win;
          idx_n   = win;
          ptr_n   = win;
          hold_n  = '0;
        end
      end
      OWN: begin
        if (!m_req[gnt_idx]) begin
          state_n = IDLE;
          gnt_n   = '0;
        end else if (bus_ack && !m_lock[gnt_idx]) begin
          state_n = IDLE;
          gnt_n   = '0;
        end else if (bus_ack) begin
          hold_n = '0;
        end else if (hold_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n = IDLE;
          gnt_n   = '0;
          tp_n    = 1'b1;
          if (timeout_cnt != 8'hFF)
            tcnt_n = timeout_cnt + 8'd1;
        end else begin
          hold_n = hold_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      m_gnt         <= '0;
      gnt_idx       <= '0;
      rr_ptr        <= IDX_W'(NUM_M - 1);
      hold_cnt      <= '0;
      timeout_pulse <= 1'b0;
      timeout_cnt   <= '0;
    end else begin
      state         <= state_n;
      m_gnt         <= gnt_n;
      gnt_idx       <= idx_n;
      rr_ptr        <= ptr_n;
      hold_cnt      <= hold_n;
      timeout_pulse <= tp_n;
      timeout_cnt   <= tcnt_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, corner sequences,
// and random traffic against a cycle-level reference model.
module tb_bus_arbiter;
  localparam int NM = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NM-1:0] m_req = '0;
  logic [NM-1:0] m_lock = '0;
  logic          bus_ack = 1'b0;
  logic [NM-1:0] m_gnt;
  logic [1:0]    gnt_idx;
  logic          bus_busy;
  logic          timeout_pulse;
  logic [7:0]    timeout_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: owner -1 means bus idle
  int own = -1;
  int ridx = 0;
  int rptr = NM - 1;
  int rhold = 0;
  int rtp = 0;
  int rtc = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
  } vec_t;

  vec_t tv[20];

  bus_arbiter #(.NUM_M(NM), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m_req(m_req),
    .m_lock(m_lock),
    .bus_ack(bus_ack),
    .m_gnt(m_gnt),
    .gnt_idx(gnt_idx),
    .bus_busy(bus_busy),
    .timeout_pulse(timeout_pulse),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] q,
                            input logic [3:0] l, input logic a);
    bit found;
    if (!r) begin
      own = -1; ridx = 0; rptr = NM - 1;
      rhold = 0; rtp = 0; rtc = 0;
      return;
    end
    rtp = 0;
    if (own < 0) begin
      found = 0;
      for (int i = 1; i <= NM; i++) begin
        int c;
        c = (rptr + i) % NM;
        if (!found && q[c]) begin
          found = 1;
          own = c; ridx = c; rptr = c; rhold = 0;
        end
      end
    end else if (!q[own]) begin
      own = -1;
    end else if (a && !l[own]) begin
      own = -1;
    end else if (a) begin
      rhold = 0;
    end else if (rhold == TO - 1) begin
      own = -1;
      rtp = 1;
      rtc = (rtc < 255) ? rtc + 1 : 255;
    end else begin
      rhold++;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q,
                      input logic [3:0] l, input logic a);
    rst_n = r; m_req = q; m_lock = l; bus_ack = a;
    @(posedge clk);
    #1;
    model_edge(r, q, l, a);
    chk("model gnt", 32'(m_gnt), (own < 0) ? 32'd0 : 32'd1 << own);
    chk("model busy", 32'(bus_busy), (own < 0) ? 32'd0 : 32'd1);
    chk("model idx", 32'(gnt_idx), 32'(ridx));
    chk("model tpulse", 32'(timeout_pulse), 32'(rtp));
    chk("model tcnt", 32'(timeout_cnt), 32'(rtc));
  endtask

  initial begin
    // reset, round-robin 0..3,0, then locked master 2
    tv[0]  = '{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
    tv[1]  = '{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0};
    tv[2]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h1, 2'd0, 1'b1};
    tv[3]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0};
    tv[4]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h2, 2'd1, 1'b1};
    tv[5]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 2'd1, 1'b0};
    tv[6]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h4, 2'd2, 1'b1};
    tv[7]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 2'd2, 1'b0};
    tv[8]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h8, 2'd3, 1'b1};
    tv[9]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 2'd3, 1'b0};
    tv[10] = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h1, 2'd0, 1'b1};
    tv[11] = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0};
    tv[12] = '{1'b1, 4'h4, 4'h4, 1'b0, 4'h4, 2'd2, 1'b1};
    tv[13] = '{1'b1, 4'h4, 4'h4, 1'b1, 4'h4, 2'd2, 1'b1};
    tv[14] = '{1'b1, 4'h4, 4'h4, 1'b0, 4'h4, 2'd2, 1'b1};
    tv[15] = '{1'b1, 4'h4, 4'h4, 1'b1, 4'h4, 2'd2, 1'b1};
    tv[16] = '{1'b1, 4'h4, 4'h4, 1'b0, 4'h4, 2'd2, 1'b1};
    tv[17] = '{1'b1, 4'h4, 4'h4, 1'b1, 4'h4, 2'd2, 1'b1};
    tv[18] = '{1'b1, 4'h4, 4'h0, 1'b1, 4'h0, 2'd2, 1'b0};
    tv[19] = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd2, 1'b0};

    for (int i = 0; i < 20; i++) begin
      step(tv[i].rst_n, tv[i].req, tv[i].lock, tv[i].ack);
      chk($sformatf("vec%0d gnt", i), 32'(m_gnt), 32'(tv[i].gnt));
      chk($sformatf("vec%0d idx", i), 32'(gnt_idx), 32'(tv[i].idx));
      chk($sformatf("vec%0d busy", i), 32'(bus_busy), 32'(tv[i].busy));
      chk($sformatf("vec%0d tcnt", i), 32'(timeout_cnt), 32'd0);
    end

    // watchdog: master 1 stalls with no ack
    for (int k = 0; k < TO; k++) begin
      step(1'b1, 4'h2, 4'h0, 1'b0);
      chk("wd hold gnt", 32'(m_gnt), 32'h2);
      chk("wd hold tpulse", 32'(timeout_pulse), 32'd0);
    end
    step(1'b1, 4'h2, 4'h0, 1'b0);
    chk("wd fire gnt", 32'(m_gnt), 32'h0);
    chk("wd fire tpulse", 32'(timeout_pulse), 32'd1);
    chk("wd fire tcnt", 32'(timeout_cnt), 32'd1);
    step(1'b1, 4'h0, 4'h0, 1'b0);
    chk("wd pulse width", 32'(timeout_pulse), 32'd0);

    // ack on the edge the watchdog would fire
    step(1'b1, 4'h2, 4'h0, 1'b0);
    for (int k = 0; k < TO - 1; k++) step(1'b1, 4'h2, 4'h0, 1'b0);
    step(1'b1, 4'h2, 4'h0, 1'b1);
    chk("edge ack tpulse", 32'(timeout_pulse), 32'd0);
    chk("edge ack tcnt", 32'(timeout_cnt), 32'd1);
    chk("edge ack gnt", 32'(m_gnt), 32'h0);
    step(1'b1, 4'h0, 4'h0, 1'b0);

    // abandon by owner 3
    step(1'b1, 4'h8, 4'h0, 1'b0);
    chk("abandon grant", 32'(m_gnt), 32'h8);
    step(1'b1, 4'h0, 4'h0, 1'b0);
    chk("abandon gnt", 32'(m_gnt), 32'h0);
    chk("abandon tpulse", 32'(timeout_pulse), 32'd0);
    chk("abandon tcnt", 32'(timeout_cnt), 32'd1);

    // reset during OWN restarts the pointer at NUM_M-1
    step(1'b1, 4'h1, 4'h0, 1'b0);
    chk("midrst grant", 32'(m_gnt), 32'h1);
    step(1'b0, 4'hF, 4'h0, 1'b0);
    chk("midrst gnt", 32'(m_gnt), 32'h0);
    chk("midrst tcnt", 32'(timeout_cnt), 32'd0);
    step(1'b1, 4'hF, 4'h0, 1'b0);
    chk("midrst ptr", 32'(m_gnt), 32'h1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic [3:0] q;
      logic [3:0] l;
      logic       a;
      r = ($urandom_range(0, 99) != 0);
      q = 4'($urandom);
      if ($urandom_range(0, 3) == 0) q = 4'h0;
      l = 4'($urandom) & 4'($urandom);
      a = ($urandom_range(0, 9) < 3);
      step(r, q, l, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
